// File: rtl/tile_load_sequencer_if.sv
// rtl/tile_load_sequencer_if.sv - element stream, buffer write and tile hand-off bundle
interface tile_load_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_bank;
  logic                  tile_ready;
  logic                  rd_bank;
  logic                  tile_release;

  // Sequencer side: consumes the stream and the release, drives the buffer and hand-off.
  modport master (
    input  s_valid, s_data, tile_release,
    output s_ready, wr_enable, wr_addr, wr_data, wr_bank, tile_ready, rd_bank
  );

  // Environment side: producer, buffer and feeder.
  modport slave (
    output s_valid, s_data, tile_release,
    input  s_ready, wr_enable, wr_addr, wr_data, wr_bank, tile_ready, rd_bank
  );
endinterface

// File: rtl/tile_load_sequencer.sv
// rtl/tile_load_sequencer.sv - ping-pong tile write sequencer with bank hand-off
module tile_load_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_SIZE  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic [15:0] tile_count_o,
  tile_load_sequencer_if.master bus
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TILE_SIZE - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wb_q, wb_d;
  logic [1:0]            full_q, full_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [15:0]           tile_count_q, tile_count_d;
  logic                  wr_enable_q, wr_enable_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_bank_q, wr_bank_d;
  // A tile finishes on the edge its write is issued, one edge after its last handshake.
  logic                  done_q, done_d;
  logic                  done_bank_q, done_bank_d;

  logic s_ready;
  logic hs;
  logic last_hs;
  logic rel;

  // Accept only while filling and the bank under the write pointer is not held by the consumer.
  assign s_ready = (state_q == FILL) && !full_q[wb_q];
  // An abort on the same edge discards the offered element along with the partial tile.
  assign hs      = bus.s_valid && s_ready && !abort_i;
  assign last_hs = hs && (cnt_q == LAST_ADDR);
  assign rel     = bus.tile_release && full_q[rd_bank_q];

  assign bus.s_ready    = s_ready;
  assign bus.wr_enable  = wr_enable_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.tile_ready = full_q[rd_bank_q];
  assign bus.rd_bank    = rd_bank_q;
  assign busy_o         = (state_q == FILL);
  assign tile_count_o   = tile_count_q;

  // Next-state: control, write port staging and bank occupancy bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_d         = wb_q;
    full_d       = full_q;
    rd_bank_d    = rd_bank_q;
    tile_count_d = tile_count_q;
    wr_enable_d  = hs;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_bank_d    = wr_bank_q;
    done_d       = last_hs;
    done_bank_d  = wb_q;

    if (hs) begin
      wr_addr_d = cnt_q;
      wr_data_d = bus.s_data;
      wr_bank_d = wb_q;
    end

    // Release and completion always touch different banks, so both can apply together.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (done_q) begin
      full_d[done_bank_q] = 1'b1;
      tile_count_d        = tile_count_q + 16'd1;
    end

    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        FILL: begin
          if (hs) begin
            if (last_hs) begin
              cnt_d = '0;
              wb_d  = ~wb_q;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with asynchronous clear; a reset forgets every partial and complete tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_q         <= 1'b0;
      full_q       <= 2'b00;
      rd_bank_q    <= 1'b0;
      tile_count_q <= 16'd0;
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_bank_q    <= 1'b0;
      done_q       <= 1'b0;
      done_bank_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_q         <= wb_d;
      full_q       <= full_d;
      rd_bank_q    <= rd_bank_d;
      tile_count_q <= tile_count_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_bank_q    <= wr_bank_d;
      done_q       <= done_d;
      done_bank_q  <= done_bank_d;
    end
  end

endmodule
